// File: rtl/noise_pkg.sv
// Shared constants and FSM state type for the noise generator SPI configuration path.
package noise_pkg;

  localparam int NOISE_FRAME_BITS   = 40;
  localparam int NOISE_DIV_W        = 17;
  localparam int NOISE_LFSR_W       = 23;
  localparam int NOISE_DEFAULT_DIV  = 13000;
  localparam int NOISE_DEFAULT_SEED = 111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    COMMIT = 2'd2
  } noise_cfg_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchroniser for one asynchronous input with registered rise/fall strobes.
// level_o is the stage behind the synchroniser output, so it lines up with the edge strobes.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   cur;

  assign cur = sync_q[SYNC_STAGES-1];

  // SPI lines idle high, so everything resets to 1 and no edge fires on release.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= cur;
      rise_q <= cur & ~prev_q;
      fall_q <= ~cur & prev_q;
    end
  end

  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/noise_spi_cfg.sv
// SPI frame receiver that owns the noise generator divider and LFSR seed.
// Both fields are replaced together on a clean 40-bit frame, with a one-cycle cfg_load.
//
//   state  | meaning
//   IDLE   | waiting for chip select to fall
//   RECV   | shifting bits on each synchronised SPI clock fall
//   COMMIT | one cycle: accept frame (cfg_load) or reject it (frame_err)
module noise_spi_cfg
  import noise_pkg::*;
#(
  parameter int FRAME_BITS   = NOISE_FRAME_BITS,
  parameter int DIV_W        = NOISE_DIV_W,
  parameter int LFSR_W       = NOISE_LFSR_W,
  parameter int SYNC_STAGES  = 2,
  parameter int DEFAULT_DIV  = NOISE_DEFAULT_DIV,
  parameter int DEFAULT_SEED = NOISE_DEFAULT_SEED
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              spi_clock,
  input  logic              spi_data,
  input  logic              spi_cs,
  output logic [DIV_W-1:0]  freq_div,
  output logic [LFSR_W-1:0] lfsr_seed,
  output logic              cfg_load,
  output logic              frame_err,
  output logic              busy
);

  localparam int                CNT_W    = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_BITS + 1);
  localparam logic [DIV_W-1:0]  DIV_RST  = DIV_W'(DEFAULT_DIV);
  localparam logic [LFSR_W-1:0] SEED_RST = LFSR_W'(DEFAULT_SEED);

  logic sck_fall, sck_rise, sck_level;
  logic data_s, data_rise, data_fall;
  logic cs_fall, cs_rise, cs_level;
  logic unused_edges;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk_i   (sys_clk),
    .rst_n_i (sys_rst_n),
    .async_i (spi_clock),
    .level_o (sck_level),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .clk_i   (sys_clk),
    .rst_n_i (sys_rst_n),
    .async_i (spi_data),
    .level_o (data_s),
    .rise_o  (data_rise),
    .fall_o  (data_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk_i   (sys_clk),
    .rst_n_i (sys_rst_n),
    .async_i (spi_cs),
    .level_o (cs_level),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  assign unused_edges = ^{sck_rise, sck_level, data_rise, data_fall, cs_level};

  noise_cfg_state_t  state_q, state_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]  freq_div_q, freq_div_d;
  logic [LFSR_W-1:0] seed_q, seed_d;
  logic              cfg_load_q, cfg_load_d;
  logic              frame_err_q, frame_err_d;
  logic [LFSR_W-1:0] seed_field;

  assign seed_field = sr_q[LFSR_W-1:0];

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    freq_div_d  = freq_div_q;
    seed_d      = seed_q;
    cfg_load_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = RECV;
          sr_d      = '0;
          bit_cnt_d = '0;
        end
      end
      RECV: begin
        // A coincident final clock fall is shifted before COMMIT reads the count.
        if (sck_fall) begin
          sr_d = {sr_q[FRAME_BITS-2:0], data_s};
          if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + 1'b1;
        end
        if (cs_rise) state_d = COMMIT;
      end
      COMMIT: begin
        state_d = IDLE;
        if (bit_cnt_q == CNT_FULL) begin
          freq_div_d = sr_q[FRAME_BITS-1 -: DIV_W];
          seed_d     = (seed_field == '0) ? SEED_RST : seed_field;
          cfg_load_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      freq_div_q  <= DIV_RST;
      seed_q      <= SEED_RST;
      cfg_load_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      freq_div_q  <= freq_div_d;
      seed_q      <= seed_d;
      cfg_load_q  <= cfg_load_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign freq_div  = freq_div_q;
  assign lfsr_seed = seed_q;
  assign cfg_load  = cfg_load_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/noise_spi_cfg.md
Name: noise_spi_cfg

Overview:
- Receives 40-bit configuration frames from the MCU over a 3-wire SPI link (spi_clock, spi_data, spi_cs) and synchronises them into sys_clk.
- Holds the noise generator's active frequency divider and LFSR seed.
- Issues a one-cycle load strobe so the generator reloads its divider and LFSR atomically.
- Sits between the MCU SPI pins and the noise generator core; it is the only writer of that core's configuration.

Parameters:
- FRAME_BITS, 40, total frame length in bits.
- DIV_W, 17, frequency-divider width; occupies frame bits [39:23].
- LFSR_W, 23, LFSR seed width; occupies frame bits [22:0]. DIV_W + LFSR_W must equal FRAME_BITS.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser (minimum 2).
- DEFAULT_DIV, 13000, divider value after reset.
- DEFAULT_SEED, 111, seed value after reset, and the substitute for any all-zero seed.

Ports:
- sys_clk, in, 1, system clock; the only clock in the block.
- sys_rst_n, in, 1, reset; asynchronous assert, active-low.
- spi_clock, in, 1, SPI clock, asynchronous to sys_clk; data is sampled on its falling edge.
- spi_data, in, 1, SPI data, MSB first.
- spi_cs, in, 1, chip select, active-low.
- freq_div, out, DIV_W, active divider value.
- lfsr_seed, out, LFSR_W, active seed value; never zero.
- cfg_load, out, 1, one-cycle strobe issued when freq_div and lfsr_seed change.
- frame_err, out, 1, one-cycle strobe issued when a frame is rejected.
- busy, out, 1, high while a frame is being received.

Behaviour:
- Reset values: freq_div = DEFAULT_DIV, lfsr_seed = DEFAULT_SEED, cfg_load = 0, frame_err = 0, busy = 0, FSM in IDLE, shift register = 0, bit_cnt = 0. Synchronisers reset to 1 (SPI idle-high).
- Synchronisation: spi_clock, spi_data and spi_cs each pass through SYNC_STAGES flops. Edges are detected from the last synchronised stage and the registered copy behind it.
  - sck_fall = previous 1, current 0.
  - cs_fall / cs_rise defined the same way on spi_cs.
  - Constraint: spi_clock high and low phases must each be at least 3 sys_clk periods.
- FSM states: IDLE, RECV, COMMIT.
  - IDLE -> RECV on cs_fall. Clear the shift register and bit_cnt. busy = 1 from the next cycle.
  - RECV, on sck_fall: shift register <= {sr[FRAME_BITS-2:0], synced data}. bit_cnt increments and saturates at FRAME_BITS+1, which marks an overrun.
  - RECV -> COMMIT on cs_rise.
  - Simultaneous sck_fall and cs_rise in the same cycle: shift the bit first, then evaluate the frame using the updated count.
  - COMMIT is always exactly one cycle, then returns to IDLE with busy = 0.
    - bit_cnt == FRAME_BITS: freq_div <= sr[39:23]; lfsr_seed <= sr[22:0], or DEFAULT_SEED if that field is 0. cfg_load = 1 on the following cycle.
    - Any other count (short or overrun): outputs are unchanged and frame_err = 1 on the following cycle.
  - A cs_fall seen in COMMIT is ignored. The MCU guarantees at least 4 sys_clk cycles of spi_cs high between frames.
- Latency: 1 cycle from the COMMIT cycle to the new outputs, with cfg_load asserted in that same cycle. End to end, this is SYNC_STAGES + 3 sys_clk cycles from the physical rise of spi_cs.
- The outputs update in a single cycle (never one field without the other), and hold value between commits.
- freq_div = 0 is legal and is passed through unchanged.
- sck_fall while in IDLE (no chip select) is ignored.
- A reset asserted mid-frame aborts the frame: all state returns to its reset value and no strobe is issued.

Decomposition:
- Shared package noise_pkg holds:
  - constants NOISE_FRAME_BITS, NOISE_DIV_W, NOISE_LFSR_W, NOISE_DEFAULT_DIV, NOISE_DEFAULT_SEED;
  - the FSM state enum noise_cfg_state_t {IDLE, RECV, COMMIT}.
- One sub-module, sync_edge_det: a parameterised SYNC_STAGES synchroniser with registered rise/fall outputs, instantiated three times.

Test Plan:
- Reset release with SPI idle -> freq_div = 13000, lfsr_seed = 111, no cfg_load, busy = 0.
- Valid frame with freq_div 0x00400, seed 0x5A5A5A, MSB first -> exactly one cfg_load pulse; the outputs update in that same cycle, SYNC_STAGES+3 cycles after spi_cs rises.
- Valid frame with seed field 0 and freq_div 0x1FFFF -> freq_div = 0x1FFFF, lfsr_seed = 111, cfg_load pulses.
- Short frame (39 bits) and overrun frame (41 bits) -> one frame_err pulse each; outputs keep their prior values; no cfg_load.
- Last sck fall coincident with spi_cs rise after 40 bits -> frame accepted, cfg_load pulses, final bit present in lfsr_seed[0].
- sys_rst_n asserted after 20 bits, then a full valid frame -> no strobe during the aborted frame; the second frame commits normally.
